mod_residue_reducer: RTL

Sequential modular reduction stage that sits directly downstream of the modular multiplier's partial-product accumulator. It takes a wide, unreduced sum S and returns S mod MOD_P, always strictly less than MOD_P. It uses restoring shift-subtract, one input bit per cycle, with valid/ready handshakes on both sides. It replaces the unbounded subtract loop, so latency is fixed and the block is synthesizable.

---
 rtl/mod_residue_reducer.sv | 107 ++++++++++
 1 files changed

// File: rtl/mod_residue_reducer.sv
// mod_residue_reducer: sequential S mod MOD_P reduction by restoring
// shift-subtract, one input bit per cycle, with valid/ready on both sides.
// The input is consumed MSB first. Each step keeps the running remainder
// below MOD_P, so a single conditional subtract is enough.
module mod_residue_reducer #(
  parameter  int IN_W  = 16,
  parameter  int MOD_P = 47,
  localparam int OUT_W = $clog2(MOD_P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_res,
  output logic             busy
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [OUT_W:0]   MOD_V    = (OUT_W+1)'(MOD_P);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  sreg;
  logic [OUT_W:0]   rem;
  logic [OUT_W:0]   rem_next;
  logic [CNT_W-1:0] cnt;

  // One restoring step: shift in the next bit, subtract the modulus once if
  // needed. With r < MOD_P the shifted value is at most 2*MOD_P-1, which fits
  // in OUT_W+1 bits, so the result is again < MOD_P.
  function automatic logic [OUT_W:0] reduce_step(input logic [OUT_W:0] r,
                                                 input logic           b);
    logic [OUT_W:0] t;
    t = (r << 1) | {{OUT_W{1'b0}}, b};
    if (t >= MOD_V) begin
      t = t - MOD_V;
    end
    return t;
  endfunction

  assign rem_next  = reduce_step(rem, sreg[IN_W-1]);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  // Operand shift register: loaded on accept, shifted left each RUN cycle so
  // the bit under consideration is always the MSB. Its contents do not matter
  // outside RUN, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sreg <= in_data;
    end else if (state == RUN) begin
      sreg <= sreg << 1;
    end
  end

  // Control FSM with registered remainder, counter and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_res   <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem   <= '0;
            cnt   <= CNT_INIT;
            state <= RUN;
          end
        end
        RUN: begin
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            out_res   <= rem_next[OUT_W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Leaving DONE returns to IDLE first, so a sum offered in this same
          // cycle is only taken on the following edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
